// File: rtl/out_pcm_mc.sv
// G.711 multi-channel TDM transmitter: per-channel compressing holding registers feeding
// a framed MSB-first serial output, with sticky underrun and frame-error flags.
module out_pcm_mc #(
    parameter int unsigned  NCH = 4,
    localparam int unsigned CW  = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CW-1:0]  in_ch,
    input  logic           in_law,
    input  logic [13:0]    in_sr,
    input  logic           frame_start,
    output logic           pcm_out,
    output logic           pcm_fs,
    output logic [NCH-1:0] underrun,
    output logic           frame_err,
    input  logic           scan_in0,
    input  logic           scan_en,
    output logic           scan_out0
);

    localparam int unsigned NBITS = NCH * 8;
    localparam int unsigned CNTW  = $clog2(NBITS);

    typedef enum logic {StIdle, StShift} state_t;

    state_t          r_state, w_state_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [7:0]      r_shift;
    logic            r_fs;
    logic [NCH-1:0]  r_valid, r_law, r_underrun;
    logic            r_frame_err;
    logic [7:0]      r_code [NCH];

    logic            w_load;
    logic [CW-1:0]   w_load_ch;
    logic [7:0]      w_load_code;
    logic            w_ready;
    logic            w_wr;
    logic [7:0]      w_wr_code;
    logic            w_unused_scan;

    function automatic logic [7:0] mulaw_enc(input logic [13:0] sr);
        logic       neg;
        logic [13:0] mag;
        logic [13:0] m;
        logic [2:0] seg;
        logic [3:0] mant;
        neg = sr[13];
        mag = neg ? (~sr + 14'd1) : sr;
        if (mag > 14'd8158) mag = 14'd8158;
        m   = mag + 14'd33;
        seg = 3'd0;
        for (int i = 5; i <= 12; i++) begin
            if (m[i]) seg = 3'(i - 5);
        end
        // widen before +1 so seg = 7 does not wrap the shift amount
        mant = 4'(m >> ({1'b0, seg} + 4'd1));
        return ~{neg, seg, mant};
    endfunction

    // y is the sample already shifted right by one (13-bit two's complement)
    function automatic logic [7:0] alaw_enc(input logic [12:0] y);
        logic        neg;
        logic [11:0] mag;
        logic [2:0]  seg;
        logic [3:0]  mant;
        neg = y[12];
        mag = neg ? ~y[11:0] : y[11:0];
        seg = 3'd0;
        if (mag < 12'd32) begin
            mant = mag[4:1];
        end else begin
            for (int i = 5; i <= 11; i++) begin
                if (mag[i]) seg = 3'(i - 4);
            end
            mant = 4'(mag >> seg);
        end
        return {~neg, seg, mant} ^ 8'h55;
    endfunction

    assign w_wr_code = in_law ? alaw_enc(in_sr[13:1]) : mulaw_enc(in_sr);

    always_comb begin
        w_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CW'(i)) w_ready = ~r_valid[i];
        end
    end

    assign in_ready  = w_ready;
    assign w_wr      = in_valid & w_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_load_ch   = '0;
        unique case (r_state)
            StIdle: begin
                if (frame_start) begin
                    w_state_nxt = StShift;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            StShift: begin
                if (r_cnt == CNTW'(NBITS - 1)) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_load    = (w_cnt_inc[2:0] == 3'd0);
                    w_load_ch = w_cnt_inc[CNTW-1:3];
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_load_code = 8'hFF;
        for (int i = 0; i < NCH; i++) begin
            if (w_load_ch == CW'(i)) begin
                w_load_code = r_valid[i] ? r_code[i] : (r_law[i] ? 8'hD5 : 8'hFF);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_fs        <= 1'b0;
            r_valid     <= '0;
            r_law       <= '0;
            r_underrun  <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NCH; i++) r_code[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fs    <= (r_state == StIdle) && frame_start;
            r_shift <= w_load ? w_load_code : {r_shift[6:0], 1'b0};
            if ((r_state == StShift) && frame_start) r_frame_err <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (w_load && (w_load_ch == CW'(i))) begin
                    r_valid[i] <= 1'b0;
                    if (!r_valid[i]) r_underrun[i] <= 1'b1;
                end
                // a write to a just-drained empty channel lands after the idle-code load
                if (w_wr && (in_ch == CW'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_code[i]  <= w_wr_code;
                    r_law[i]   <= in_law;
                end
            end
        end
    end

    assign pcm_out       = (r_state == StShift) & r_shift[7];
    assign pcm_fs        = r_fs;
    assign underrun      = r_underrun;
    assign frame_err     = r_frame_err;
    assign scan_out0     = 1'b0;
    assign w_unused_scan = scan_in0 ^ scan_en;

endmodule

// File: tb/tb_out_pcm_mc.sv
// Directed bench for out_pcm_mc: frame-level behavioural model checked every cycle,
// plus literal expectations for captured slot bytes and flags.
module tb_out_pcm_mc;

    localparam int NCH = 4;
    localparam int NB  = NCH * 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     in_ch = 2'd0;
    logic           in_law = 1'b0;
    logic [13:0]    in_sr = 14'd0;
    logic           frame_start = 1'b0;
    logic           pcm_out;
    logic           pcm_fs;
    logic [NCH-1:0] underrun;
    logic           frame_err;
    logic           scan_in0 = 1'b0;
    logic           scan_en = 1'b0;
    logic           scan_out0;

    out_pcm_mc #(.NCH(NCH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .in_law      (in_law),
        .in_sr       (in_sr),
        .frame_start (frame_start),
        .pcm_out     (pcm_out),
        .pcm_fs      (pcm_fs),
        .underrun    (underrun),
        .frame_err   (frame_err),
        .scan_in0    (scan_in0),
        .scan_en     (scan_en),
        .scan_out0   (scan_out0)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit [7:0] mu_enc(input logic [13:0] sr);
        int s, a, m, seg, mant;
        bit neg;
        s   = int'($signed(sr));
        neg = (s < 0);
        a   = neg ? -s : s;
        if (a > 8158) a = 8158;
        m   = a + 33;
        seg = 0;
        while ((m >> (seg + 6)) != 0) seg++;
        mant = (m >> (seg + 1)) & 15;
        return ~8'((neg ? 128 : 0) + seg * 16 + mant);
    endfunction

    function automatic bit [7:0] a_enc(input logic [13:0] sr);
        int s, y, mag, seg, mant;
        bit neg;
        s   = int'($signed(sr));
        y   = s >>> 1;
        neg = (y < 0);
        mag = neg ? -y - 1 : y;
        if (mag < 32) begin
            seg  = 0;
            mant = (mag >> 1) & 15;
        end else begin
            seg = 1;
            while ((mag >> (seg + 5)) != 0) seg++;
            mant = (mag >> seg) & 15;
        end
        return 8'((neg ? 0 : 128) + seg * 16 + mant) ^ 8'h55;
    endfunction

    bit           m_valid [NCH];
    bit [7:0]     m_code  [NCH];
    bit           m_law   [NCH];
    bit [7:0]     m_frame [NCH];
    bit [NCH-1:0] m_underrun = '0;
    bit           m_frame_err = 1'b0;
    bit           m_active = 1'b0;
    int           m_pos = 0;

    always @(posedge clk or negedge reset) begin : mdl
        bit rdy;
        int ch, ld;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_valid[i] = 1'b0;
                m_law[i]   = 1'b0;
            end
            m_underrun  = '0;
            m_frame_err = 1'b0;
            m_active    = 1'b0;
            m_pos       = 0;
        end else begin
            ch  = int'(in_ch);
            rdy = (ch < NCH) && !m_valid[ch];
            ld  = -1;
            if (m_active) begin
                if (frame_start) m_frame_err = 1'b1;
                if (m_pos == NB - 1) begin
                    m_active = 1'b0;
                end else begin
                    m_pos++;
                    if (m_pos % 8 == 0) ld = m_pos / 8;
                end
            end else if (frame_start) begin
                m_active = 1'b1;
                m_pos    = 0;
                ld       = 0;
            end
            if (ld >= 0) begin
                if (m_valid[ld]) begin
                    m_frame[ld] = m_code[ld];
                    m_valid[ld] = 1'b0;
                end else begin
                    m_frame[ld]    = m_law[ld] ? 8'hD5 : 8'hFF;
                    m_underrun[ld] = 1'b1;
                end
            end
            if (in_valid && rdy) begin
                m_valid[ch] = 1'b1;
                m_code[ch]  = in_law ? a_enc(in_sr) : mu_enc(in_sr);
                m_law[ch]   = in_law;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit e_out, e_rdy;
        int c;
        #2;
        e_out = m_active ? m_frame[m_pos / 8][7 - (m_pos % 8)] : 1'b0;
        c     = int'(in_ch);
        e_rdy = (c < NCH) && !m_valid[c];
        check("model_pcm_out", pcm_out, e_out);
        check("model_pcm_fs", pcm_fs, m_active && (m_pos == 0));
        check("model_underrun", underrun, m_underrun);
        check("model_frame_err", frame_err, m_frame_err);
        check("model_in_ready", in_ready, e_rdy);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [7:0] cap [NCH];
    int  fs_count;
    bit  fs_first, rdy_slot0;
    bit  mid_wr_en = 1'b0;
    int  mid_wr_i, mid_wr_ch, mid_wr_sr;
    bit  fs_pulse_en = 1'b0;
    int  fs_pulse_i;

    task automatic do_write(input int ch, input bit law, input int sr, output bit rdy);
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_law   = law;
        in_sr    = 14'(sr);
        #1 rdy = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fs_count = 0;
        for (int i = 0; i < NB; i++) begin
            cap[i / 8][7 - (i % 8)] = pcm_out;
            if (pcm_fs) fs_count++;
            if (i == 0) begin
                fs_first  = pcm_fs;
                rdy_slot0 = in_ready;
            end
            if (mid_wr_en && i == mid_wr_i) begin
                in_valid = 1'b1;
                in_ch    = 2'(mid_wr_ch);
                in_law   = 1'b0;
                in_sr    = 14'(mid_wr_sr);
            end
            if (mid_wr_en && i == mid_wr_i + 1) begin
                in_valid = 1'b0;
                in_ch    = 2'd0;
            end
            if (fs_pulse_en && i == fs_pulse_i) frame_start = 1'b1;
            if (fs_pulse_en && i == fs_pulse_i + 1) frame_start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin : main
        bit r;
        int quiet;

        // pin the model encoders to hand-computed codes
        check("pin_mu_0", mu_enc(14'd0), 8'hFF);
        check("pin_mu_8191", mu_enc(14'd8191), 8'h80);
        check("pin_mu_neg100", mu_enc(14'h3F9C), 8'h5F);
        check("pin_mu_min", mu_enc(14'h2000), 8'h00);
        check("pin_a_8190", a_enc(14'd8190), 8'hAA);
        check("pin_a_neg2", a_enc(14'h3FFE), 8'h55);
        check("pin_a_min", a_enc(14'h2000), 8'h2A);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_pcm_out", pcm_out, 0);
        check("rst_pcm_fs", pcm_fs, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_scan_out0", scan_out0, 0);
        for (int ch = 0; ch < NCH; ch++) begin
            in_ch = 2'(ch);
            #1 check("rst_in_ready", in_ready, 1);
        end
        @(negedge clk);
        reset = 1'b1;

        // four channels, both laws
        do_write(0, 1'b0, 0, r);
        check("a_wr_ready", r, 1);
        do_write(1, 1'b0, 8191, r);
        do_write(2, 1'b1, 8190, r);
        do_write(3, 1'b1, -2, r);
        run_frame();
        check("a_slot0", cap[0], 8'hFF);
        check("a_slot1", cap[1], 8'h80);
        check("a_slot2", cap[2], 8'hAA);
        check("a_slot3", cap[3], 8'h55);
        check("a_fs_first", fs_first, 1);
        check("a_fs_count", fs_count, 1);
        check("a_underrun", underrun, 0);
        for (int ch = 0; ch < NCH; ch++) begin
            in_ch = 2'(ch);
            #1 check("a_ready_after", in_ready, 1);
        end

        // fresh reset, only ch1 written: idle codes elsewhere
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_write(1, 1'b0, 100, r);
        run_frame();
        check("b_slot0", cap[0], 8'hFF);
        check("b_slot1", cap[1], 8'hDF);
        check("b_slot2", cap[2], 8'hFF);
        check("b_slot3", cap[3], 8'hFF);
        check("b_underrun", underrun, 4'b1101);

        // double write, plus a write colliding with slot1 load
        do_write(0, 1'b0, -100, r);
        check("c_first_ready", r, 1);
        do_write(0, 1'b0, 5, r);
        check("c_second_ready", r, 0);
        in_ch     = 2'd0;
        mid_wr_en = 1'b1;
        mid_wr_i  = 7;
        mid_wr_ch = 1;
        mid_wr_sr = 8191;
        run_frame();
        mid_wr_en = 1'b0;
        check("c_ready_slot0", rdy_slot0, 1);
        check("c_slot0", cap[0], 8'h5F);
        check("c_slot1_idle", cap[1], 8'hFF);
        check("c_underrun", underrun, 4'b1111);
        in_ch = 2'd1;
        #1 check("c_ch1_pending", in_ready, 0);

        // frame_start mid-frame is ignored
        check("d_frame_err_pre", frame_err, 0);
        fs_pulse_en = 1'b1;
        fs_pulse_i  = 9;
        run_frame();
        fs_pulse_en = 1'b0;
        check("d_slot0", cap[0], 8'hFF);
        check("d_slot1", cap[1], 8'h80);
        check("d_frame_err", frame_err, 1);
        check("d_fs_count", fs_count, 1);
        quiet = 0;
        repeat (16) begin
            if (pcm_out || pcm_fs) quiet++;
            @(negedge clk);
        end
        check("d_quiet_after", quiet, 0);

        // reset at cycle 12 aborts the frame
        do_write(0, 1'b0, 8191, r);
        do_write(2, 1'b1, 8190, r);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (11) @(negedge clk);
        check("e_pcm_out_pre", pcm_out, 1);
        in_ch = 2'd2;
        reset = 1'b0;
        #1;
        check("e_pcm_out", pcm_out, 0);
        check("e_pcm_fs", pcm_fs, 0);
        check("e_underrun", underrun, 0);
        check("e_frame_err", frame_err, 0);
        check("e_ready_ch2", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_frame();
        for (int k = 0; k < NCH; k++) check("e_slot_idle", cap[k], 8'hFF);
        check("e_underrun_after", underrun, 4'b1111);
        check("e_fs_first", fs_first, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_pcm_mc.md
OUT_PCM_MC -- requirements
Module: out_pcm_mc

Interface
REQ-001 SHALL take parameter NCH, default 4: number of TDM channels, range 2..32.
REQ-002 SHALL derive CW = max(1, clog2(NCH)) as the channel index width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  sample write request.
REQ-006 Port in_ready  output  1  write accepted when in_valid && in_ready at a clock edge.
REQ-007 Port in_ch  input  CW  target channel (values >= NCH are illegal and ignored: in_ready = 0).
REQ-008 Port in_law  input  1  0 = mu-law, 1 = A-law.
REQ-009 Port in_sr  input  14  linear sample, two's complement.
REQ-010 Port frame_start  input  1  one-cycle 8 kHz frame strobe.
REQ-011 Port pcm_out  output  1  serial G.711 TDM data, MSB first.
REQ-012 Port pcm_fs  output  1  high during the first bit of each frame.
REQ-013 Port underrun  output  NCH  sticky per-channel flag: idle code was sent for that channel.
REQ-014 Port frame_err  output  1  sticky flag: frame_start arrived during an active frame.
REQ-015 Ports scan_in0, scan_en (input, 1) and scan_out0 (output, 1) are reserved for scan insertion; RTL drives scan_out0 = 0.

Function
REQ-016 SHALL compress in_sr at write time and store an 8-bit code plus a law bit in a per-channel holding register with a valid bit.
REQ-017 in_ready SHALL be !valid[in_ch] (combinational); a write sets valid, a slot load clears it.
REQ-018 mu-law: neg = sr<0; m = min(|sr|, 8158) + 33; seg = (index of leading one of m) - 5; mant = m[seg+4:seg+1]; code = ~{neg, seg[2:0], mant}.
REQ-019 A-law: y = sr>>>1 (13-bit); neg = y<0; mag = neg ? -y-1 : y; if mag<32, seg = 0 and mant = mag[4:1]; else seg = (index of leading one) - 4 and mant = mag[seg+3:seg]; code = {~neg, seg, mant} ^ 8'h55.
REQ-020 FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on frame_start; SHIFT->IDLE after NCH*8 bits.
REQ-021 For slot k, bit b: pcm_out SHALL be driven in cycle 1+8k+b after the frame_start edge; pcm_fs = 1 only in cycle 1.
REQ-022 At each slot start, channel k's register SHALL be loaded into the shift register, and its valid bit cleared.
REQ-023 If valid[k] = 0 at slot start, the block SHALL send the idle code instead: 8'hFF if the channel's last law was mu-law, 8'hD5 if A-law. It SHALL also set underrun[k].
REQ-024 If a write and a slot load hit the same empty channel in one cycle, the idle code SHALL be sent and the write stored for the next frame.
REQ-025 frame_start during SHIFT SHALL be ignored and SHALL set frame_err.
REQ-026 pcm_out and pcm_fs SHALL be 0 in IDLE.
REQ-027 Flags SHALL clear only on reset.

Reset
REQ-028 On reset low, the block SHALL set state IDLE; pcm_out, pcm_fs, underrun and frame_err = 0; all valid bits = 0; all law bits = 0 (mu-law); in_ready = 1 for legal in_ch.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; the first frame_start after release SHALL start a clean frame at slot 0.

Verification
REQ-030 Write ch0 mu-law sr=0 and ch1 mu-law sr=8191, then frame_start -> slot0 = 8'hFF, slot1 = 8'h80, pcm_fs high in cycle 1 only.
REQ-031 Write ch2 A-law sr=8190 and ch3 A-law sr=-2 -> slot2 = 8'hAA, slot3 = 8'h55; after the frame, all in_ready = 1.
REQ-032 Write ch1 only, then frame_start -> ch0 = 8'hFF; ch2 and ch3 = 8'hFF; underrun = 4'b1101.
REQ-033 Write ch0 twice before the frame -> second write sees in_ready = 0; after slot0 loads, in_ready = 1 for ch0.
REQ-034 frame_start pulsed at cycle 10 of a 32-bit frame -> frame not restarted; frame_err = 1; the frame ends at cycle 32.
REQ-035 Reset pulsed at cycle 12 of a frame -> pcm_out = 0 and all flags = 0 immediately; the next frame_start sends idle codes 8'hFF on all slots.
